// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer in front of the CP0 register file: arbitrates syscall,
// interrupts and eret, stalls the pipeline, writes EPC/Cause/Status one per cycle, then redirects fetch.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] CODE_INT   = 32'h0000_0001,
  parameter logic [31:0] CODE_SYS   = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst_pc,
  input  logic        is_syscall,
  input  logic        is_eret,
  input  logic [5:0]  int_pend,
  input  logic [5:0]  intimer,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic        cp0we,
  output logic [4:0]  cp0wAddr,
  output logic [31:0] cp0wData,
  output logic [31:0] excptype,
  output logic [31:0] epc,
  output logic        stall,
  output logic        flush,
  output logic        pc_sel,
  output logic [31:0] new_pc
);

  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STATUS, REDIR, ERET} state_t;

  state_t      state, state_nx;
  logic [31:0] epc_nx, excptype_nx;
  logic        irq;
  logic        unused_bits;

  assign irq = cp0_status[0] & ~cp0_status[1] &
               ((|(int_pend & cp0_status[15:10])) | intimer[0]);

  assign unused_bits = ^{intimer[5:1], cp0_cause[15:10], cp0_cause[6:0], excptype[31:5]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      epc      <= '0;
      excptype <= '0;
    end else begin
      state    <= state_nx;
      epc      <= epc_nx;
      excptype <= excptype_nx;
    end
  end

  // IDLE decisions are gated by rst so that nothing pulses while reset is held
  always_comb begin
    state_nx    = state;
    epc_nx      = epc;
    excptype_nx = excptype;
    cp0we       = 1'b0;
    cp0wAddr    = 5'd0;
    cp0wData    = 32'h0;
    stall       = 1'b1;
    flush       = 1'b0;
    pc_sel      = 1'b0;
    new_pc      = 32'h0;
    case (state)
      IDLE: begin
        stall = 1'b0;
        if (rst && inst_valid) begin
          if (is_syscall) begin
            epc_nx      = inst_pc + 32'd4;
            excptype_nx = CODE_SYS;
            flush       = 1'b1;
            state_nx    = W_EPC;
          end else if (irq) begin
            epc_nx      = inst_pc;
            excptype_nx = CODE_INT;
            flush       = 1'b1;
            state_nx    = W_EPC;
          end else if (is_eret && cp0_status[1]) begin
            flush    = 1'b1;
            state_nx = ERET;
          end
        end
      end
      W_EPC: begin
        cp0we    = 1'b1;
        cp0wAddr = 5'd14;
        cp0wData = epc;
        state_nx = W_CAUSE;
      end
      W_CAUSE: begin
        cp0we    = 1'b1;
        cp0wAddr = 5'd13;
        cp0wData = {cp0_cause[31:16], int_pend, cp0_cause[9:7], excptype[4:0], 2'b00};
        state_nx = W_STATUS;
      end
      W_STATUS: begin
        cp0we    = 1'b1;
        cp0wAddr = 5'd12;
        cp0wData = cp0_status | 32'h2;
        state_nx = REDIR;
      end
      REDIR: begin
        pc_sel      = 1'b1;
        new_pc      = EXC_VECTOR;
        flush       = 1'b1;
        epc_nx      = '0;
        excptype_nx = '0;
        state_nx    = IDLE;
      end
      ERET: begin
        cp0we       = 1'b1;
        cp0wAddr    = 5'd12;
        cp0wData    = cp0_status & ~32'h2;
        pc_sel      = 1'b1;
        new_pc      = cp0_epc;
        epc_nx      = '0;
        excptype_nx = '0;
        state_nx    = IDLE;
      end
      default: begin
        state_nx    = IDLE;
        epc_nx      = '0;
        excptype_nx = '0;
      end
    endcase
  end

endmodule
